// File: rtl/uart_tx.sv
// uart_tx: byte-wide async serial transmitter (start, 8 data LSB first,
// optional parity, 1 or 2 stop bits). tx_busy provides flow control upstream;
// there is no internal queueing.
//
// state    | meaning
// ---------+------------------------------------------------
// S_IDLE   | line high, waiting for tx_data_valid
// S_START  | driving start bit (0) for one bit time
// S_DATA   | driving data bits 0..7, LSB first
// S_PARITY | driving parity bit (only when PARITY_EN != 0)
// S_STOP   | driving stop bit(s) (1) for STOP_BITS bit times
module uart_tx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_serial
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [2:0]      idx_q;
   logic [7:0]      shift_q;
   logic            parity_q;
   logic            busy_q;
   logic            done_q;
   logic            serial_q;

   logic            baud_tc;
   logic            parity_d;

   assign baud_tc  = (cnt_q == CNT_LAST);
   // Parity is taken from the incoming byte so it is ready when the frame starts.
   assign parity_d = (^tx_data) ^ 1'(PARITY_ODD);

   assign tx_busy   = busy_q;
   assign tx_done   = done_q;
   assign tx_serial = serial_q;

   // Frame sequencer; every output is a flop so the line never glitches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         parity_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         serial_q <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               serial_q <= 1'b1;
               cnt_q    <= '0;
               idx_q    <= '0;
               if (tx_data_valid) begin
                  shift_q  <= tx_data;
                  parity_q <= parity_d;
                  busy_q   <= 1'b1;
                  serial_q <= 1'b0;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (baud_tc) begin
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  serial_q <= shift_q[0];
                  shift_q  <= shift_q >> 1;
                  state_q  <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (baud_tc) begin
                  cnt_q <= '0;
                  if (idx_q == 3'd7) begin
                     idx_q <= '0;
                     if (PARITY_EN != 0) begin
                        serial_q <= parity_q;
                        state_q  <= S_PARITY;
                     end else begin
                        serial_q <= 1'b1;
                        state_q  <= S_STOP;
                     end
                  end else begin
                     idx_q    <= idx_q + 1'b1;
                     serial_q <= shift_q[0];
                     shift_q  <= shift_q >> 1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (baud_tc) begin
                  cnt_q    <= '0;
                  idx_q    <= '0;
                  serial_q <= 1'b1;
                  state_q  <= S_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (baud_tc) begin
                  cnt_q <= '0;
                  if (idx_q == STOP_LAST) begin
                     // Busy drops with the done pulse so a held request is taken this cycle.
                     idx_q    <= '0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     serial_q <= 1'b1;
                     state_q  <= S_IDLE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q  <= S_IDLE;
               busy_q   <= 1'b0;
               serial_q <= 1'b1;
               cnt_q    <= '0;
               idx_q    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters share one stimulus stream
//   inst 0: no parity, 1 stop   (10-bit frame)
//   inst 1: even parity, 1 stop (11-bit frame)
//   inst 2: odd parity, 2 stops (12-bit frame)
// A frame-level model predicts the line, busy and done of each instance every cycle.
module tb_uart_tx;

   localparam int C = 16;

   logic       clk;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic [2:0] ser, bsy, dn;

   int checks = 0;
   int errors = 0;

   uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
      .tx_busy(bsy[0]), .tx_done(dn[0]), .tx_serial(ser[0]));
   uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
      .tx_busy(bsy[1]), .tx_done(dn[1]), .tx_serial(ser[1]));
   uart_tx #(.CLK_FREQ(16), .BAUD(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
      .tx_busy(bsy[2]), .tx_done(dn[2]), .tx_serial(ser[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int   pe[3] = '{0, 1, 1};
   int   po[3] = '{0, 0, 1};
   int   sb[3] = '{1, 1, 2};
   int   pos[3] = '{-1, -1, -1};
   int   nb[3] = '{10, 11, 12};
   logic bits[3][12];
   logic dm[3] = '{1'b0, 1'b0, 1'b0};

   function automatic logic exp_ser(input int i);
      if (pos[i] < 0) return 1'b1;
      return bits[i][pos[i] / C];
   endfunction

   always @(posedge clk or negedge reset_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!reset_n) begin
            pos[i] = -1;
            dm[i]  = 1'b0;
         end else if (pos[i] < 0) begin
            dm[i] = 1'b0;
            if (tx_data_valid) begin
               int n;
               bits[i][0] = 1'b0;
               for (int k = 0; k < 8; k++) bits[i][1+k] = tx_data[k];
               n = 9;
               if (pe[i] != 0) begin
                  bits[i][9] = (^tx_data) ^ po[i][0];
                  n = 10;
               end
               for (int s = 0; s < sb[i]; s++) bits[i][n+s] = 1'b1;
               nb[i]  = n + sb[i];
               pos[i] = 0;
            end
         end else begin
            pos[i] = pos[i] + 1;
            if (pos[i] == nb[i] * C) begin
               pos[i] = -1;
               dm[i]  = 1'b1;
            end else begin
               dm[i] = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle compare of {serial,busy,done} against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++)
         chk($sformatf("cycle_inst%0d", i), int'({ser[i], bsy[i], dn[i]}),
             int'({exp_ser(i), pos[i] >= 0, dm[i]}));
   end

   // ---------------- directed helpers ----------------
   logic mid[3][12];
   int   bc[3];
   int   dc[3];

   task automatic wait_idle();
      int k;
      for (k = 0; k < 400 && bsy != 3'b000; k++) @(negedge clk);
      chk("idle_wait", int'(bsy), 0);
   endtask

   // Returns at the negedge inside the first cycle of the new frame.
   task automatic send(input logic [7:0] d);
      @(negedge clk);
      tx_data       = d;
      tx_data_valid = 1'b1;
      @(negedge clk);
      tx_data_valid = 1'b0;
   endtask

   // Samples each line mid-bit and counts busy/done cycles for 220 cycles.
   task automatic observe(input bit noisy);
      for (int i = 0; i < 3; i++) begin
         bc[i] = 0;
         dc[i] = 0;
      end
      for (int t = 0; t < 220; t++) begin
         if (noisy) begin
            tx_data       = (t == 40) ? 8'hFF : 8'($urandom);
            tx_data_valid = (t == 40);
         end
         for (int i = 0; i < 3; i++) begin
            if (t % C == C / 2 && t / C < 12) mid[i][t / C] = ser[i];
            bc[i] += int'(bsy[i]);
            dc[i] += int'(dn[i]);
         end
         @(negedge clk);
      end
      tx_data_valid = 1'b0;
   endtask

   function automatic logic [7:0] dec(input int i);
      logic [7:0] b;
      for (int k = 0; k < 8; k++) b[k] = mid[i][k+1];
      return b;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [9:0] lit;
      int k;
      tx_data       = 8'h00;
      tx_data_valid = 1'b0;
      reset_n       = 1'b1;
      #1 reset_n    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_serial", int'(ser), 7);
      chk("reset_busy", int'(bsy), 0);
      chk("reset_done", int'(dn), 0);
      #2 reset_n = 1'b1;
      repeat (3) @(negedge clk);

      // 0x55 on a plain frame: alternating line, fixed frame lengths
      send(8'h55);
      observe(1'b0);
      lit = 10'b10_1010_1010;
      for (int b = 0; b < 10; b++) chk($sformatf("line55_bit%0d", b), int'(mid[0][b]), int'(lit[b]));
      chk("busy_len_plain", bc[0], 160);
      chk("busy_len_parity", bc[1], 176);
      chk("busy_len_par_2stop", bc[2], 192);
      chk("done_count", dc[0], 1);

      // parity values
      wait_idle();
      send(8'h07);
      observe(1'b0);
      chk("even_par_07", int'(mid[1][9]), 1);
      wait_idle();
      send(8'h03);
      observe(1'b0);
      chk("even_par_03", int'(mid[1][9]), 0);
      chk("odd_par_03", int'(mid[2][9]), 1);
      chk("stop1_2stop", int'(mid[2][10]), 1);
      chk("stop2_2stop", int'(mid[2][11]), 1);

      // back-to-back with valid held
      wait_idle();
      @(negedge clk);
      tx_data       = 8'h12;
      tx_data_valid = 1'b1;
      @(negedge clk);
      for (k = 0; k < 400 && !dn[0]; k++) @(negedge clk);
      chk("b2b_done_seen", int'(dn[0]), 1);
      tx_data = 8'h34;
      @(negedge clk);
      chk("b2b_no_gap", int'({ser[0], bsy[0]}), 1);
      tx_data_valid = 1'b0;
      observe(1'b0);
      chk("b2b_decode", int'(dec(0)), 8'h34);
      chk("b2b_busy_len", bc[0], 160);

      // request while busy ignored, data toggling ignored
      wait_idle();
      send(8'h00);
      observe(1'b1);
      chk("busy_ignore_decode", int'(dec(0)), 8'h00);
      chk("busy_ignore_done", dc[0], 1);
      chk("busy_ignore_decode2", int'(dec(2)), 8'h00);

      // async reset mid-frame
      wait_idle();
      send(8'hA5);
      repeat (70) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_serial", int'(ser), 7);
      chk("async_rst_busy", int'(bsy), 0);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (t % 10 == 0) chk("post_rst_idle", int'({ser, bsy}), 6'b111_000);
      end
      send(8'h3C);
      observe(1'b0);
      chk("post_rst_decode0", int'(dec(0)), 8'h3C);
      chk("post_rst_decode1", int'(dec(1)), 8'h3C);

      // random traffic, model-checked every cycle
      wait_idle();
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         tx_data_valid = ($urandom_range(0, 7) == 0);
         tx_data       = 8'($urandom);
      end
      tx_data_valid = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
